// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - register map, CTRL bit positions and APB access FSM states for apb_timer
package apb_timer_pkg;

    // Word index decoded from paddr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_CMP    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions; presc occupies [CTRL_PRESC_LSB +: PRESC_WIDTH]
    localparam int CTRL_EN        = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_ONESHOT   = 2;
    localparam int CTRL_PRESC_LSB = 8;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    // Each state names the bus phase sampled on the most recent clock edge
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_DONE
    } apb_state_e;

endpackage

// File: rtl/apb_slave_if.sv
// rtl/apb_slave_if.sv - one-wait-state APB access FSM producing read/write strobes and the error response
module apb_slave_if
    import apb_timer_pkg::*;
(
    input  logic        clk,        // sole clock, rising edge
    input  logic        rst,        // asynchronous active-high reset
    input  logic        psel,       // slave select
    input  logic        penable,    // access phase
    input  logic        pwrite,     // 1 = write
    input  logic        access_err, // decoder verdict for the presented address/data
    input  logic [31:0] rdata,      // register read mux
    output logic [31:0] prdata,     // read data, valid with pready
    output logic        pready,     // high on the second access cycle
    output logic        pslverr,    // error response, valid with pready
    output logic        rd_en,      // first access cycle of a read: register mux is sampled
    output logic        wr_en       // commit strobe of an error-free write
);

    apb_state_e state;
    apb_state_e state_next;
    logic       first_access;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state   <= state_next;
            pready  <= first_access;
            pslverr <= first_access & access_err;
            prdata  <= (rd_en && !access_err) ? rdata : '0;
        end
    end

    // Dropping psel anywhere returns to IDLE, and the strobes are gated by
    // psel/penable, so an abandoned transfer leaves no trace.
    always_comb begin
        state_next   = state;
        first_access = 1'b0;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        if (!psel) begin
            state_next = ST_IDLE;
        end else if (!penable) begin
            state_next = ST_SETUP;
        end else begin
            case (state)
                ST_SETUP: begin
                    state_next   = ST_WAIT;
                    first_access = 1'b1;
                    rd_en        = !pwrite;
                end
                ST_WAIT: begin
                    // pslverr already holds this transfer's verdict here
                    state_next = ST_DONE;
                    wr_en      = pwrite & !pslverr;
                end
                default: state_next = state;
            endcase
        end
    end

endmodule

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB-programmable 32-bit timer with prescaler, compare match, one-shot mode and level irq
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int PRESC_WIDTH    = 8
) (
    input  logic                      clk,     // sole clock, rising edge
    input  logic                      rst,     // asynchronous active-high reset
    input  logic                      psel,    // slave select
    input  logic                      penable, // access phase
    input  logic                      pwrite,  // 1 = write
    input  logic [APB_ADDR_WIDTH-1:0] paddr,   // byte address
    input  logic [31:0]               pwdata,  // write data
    output logic [31:0]               prdata,  // read data, valid with pready
    output logic                      pready,  // transfer complete
    output logic                      pslverr, // error response
    output logic                      irq      // registered match & irq_en
);

    logic                   en;
    logic                   irq_en;
    logic                   oneshot;
    logic [PRESC_WIDTH-1:0] presc;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [31:0]            count;
    logic [31:0]            cmp;
    logic                   match;
    logic                   incremented;

    logic [1:0]  reg_sel;
    logic        access_err;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] rdata;
    logic [31:0] ctrl_rd;
    logic        ctrl_wr;
    logic        count_wr;
    logic        cmp_wr;
    logic        status_wr;
    logic        tick;
    logic        hit;

    assign reg_sel    = paddr[3:2];
    assign access_err = (paddr[1:0] != 2'b00)
                     || (paddr[APB_ADDR_WIDTH-1:4] != '0)
                     || (pwrite && reg_sel == REG_STATUS && pwdata[31:1] != '0);

    apb_slave_if u_apb_if (
        .clk        (clk),
        .rst        (rst),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .access_err (access_err),
        .rdata      (rdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .rd_en      (rd_en),
        .wr_en      (wr_en)
    );

    assign ctrl_wr   = wr_en && reg_sel == REG_CTRL;
    assign count_wr  = wr_en && reg_sel == REG_COUNT;
    assign cmp_wr    = wr_en && reg_sel == REG_CMP;
    assign status_wr = wr_en && reg_sel == REG_STATUS;

    assign tick = en && (presc_cnt == presc);
    // Only a freshly incremented COUNT can match, so writing CMP to the
    // current COUNT, or a reload to 0 with CMP=0, does not retrigger.
    assign hit  = incremented && (count == cmp);

    always_comb begin
        ctrl_rd                                   = '0;
        ctrl_rd[CTRL_EN]                          = en;
        ctrl_rd[CTRL_IRQ_EN]                      = irq_en;
        ctrl_rd[CTRL_ONESHOT]                     = oneshot;
        ctrl_rd[CTRL_PRESC_LSB +: PRESC_WIDTH]    = presc;
        rdata = '0;
        if (rd_en) begin
            case (reg_sel)
                REG_CTRL:   rdata = ctrl_rd;
                REG_COUNT:  rdata = count;
                REG_CMP:    rdata = cmp;
                REG_STATUS: rdata = {31'd0, match};
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en          <= 1'b0;
            irq_en      <= 1'b0;
            oneshot     <= 1'b0;
            presc       <= '0;
            presc_cnt   <= '0;
            count       <= '0;
            cmp         <= CMP_RESET;
            match       <= 1'b0;
            incremented <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en      <= pwdata[CTRL_EN];
                irq_en  <= pwdata[CTRL_IRQ_EN];
                oneshot <= pwdata[CTRL_ONESHOT];
                presc   <= pwdata[CTRL_PRESC_LSB +: PRESC_WIDTH];
            end else if (hit && oneshot) begin
                en <= 1'b0;
            end

            if (ctrl_wr || count_wr || tick) begin
                presc_cnt <= '0;
            end else if (en) begin
                presc_cnt <= presc_cnt + 1'b1;
            end

            // Priority: software write, then match reload, then tick
            incremented <= 1'b0;
            if (count_wr) begin
                count <= pwdata;
            end else if (hit) begin
                count <= '0;
            end else if (tick) begin
                count       <= count + 32'd1;
                incremented <= 1'b1;
            end

            if (cmp_wr) begin
                cmp <= pwdata;
            end

            if (hit) begin
                match <= 1'b1;
            end else if (status_wr && pwdata[0]) begin
                match <= 1'b0;
            end

            irq <= match & irq_en;
        end
    end

endmodule

// File: tb/tb_apb_timer.sv
// tb/tb_apb_timer.sv - randomized self-checking bench for apb_timer against a cycle-level reference model
module tb_apb_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;

    apb_timer #(.APB_ADDR_WIDTH(12), .PRESC_WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Reference model of the programmer-visible state
    logic        m_en, m_irq_en, m_oneshot, m_match, m_irq, m_inc;
    logic [7:0]  m_presc, m_pc;
    logic [31:0] m_count, m_cmp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_en = 1'b0; m_irq_en = 1'b0; m_oneshot = 1'b0; m_match = 1'b0;
        m_irq = 1'b0; m_inc = 1'b0; m_presc = 8'd0; m_pc = 8'd0;
        m_count = 32'd0; m_cmp = 32'hFFFF_FFFF;
    endtask

    function automatic logic m_err(input logic [11:0] a, input logic w, input logic [31:0] d);
        return (a[1:0] != 2'b00) || (a[11:4] != 8'd0) || (w && a[3:2] == 2'd3 && d[31:1] != 31'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        if (m_err(a, 1'b0, 32'd0)) return 32'd0;
        case (a[3:2])
            2'd0:    return {16'd0, m_presc, 5'd0, m_oneshot, m_irq_en, m_en};
            2'd1:    return m_count;
            2'd2:    return m_cmp;
            default: return {31'd0, m_match};
        endcase
    endfunction

    // Advance the model across one clock edge; wr marks a committing write
    task automatic m_advance(input logic wr, input logic [11:0] a, input logic [31:0] d);
        logic        w_ctrl, w_count, w_cmp, w_stat, hit, tick;
        logic        n_en, n_match, n_inc;
        logic [7:0]  n_pc;
        logic [31:0] n_count;
        w_ctrl  = wr && a[3:2] == 2'd0;
        w_count = wr && a[3:2] == 2'd1;
        w_cmp   = wr && a[3:2] == 2'd2;
        w_stat  = wr && a[3:2] == 2'd3;
        hit     = m_inc && (m_count == m_cmp);
        tick    = m_en && (m_pc == m_presc);
        n_match = hit ? 1'b1 : ((w_stat && d[0]) ? 1'b0 : m_match);
        n_count = w_count ? d : (hit ? 32'd0 : (tick ? m_count + 32'd1 : m_count));
        n_inc   = tick && !w_count && !hit;
        n_pc    = (w_ctrl || w_count || tick) ? 8'd0 : (m_en ? m_pc + 8'd1 : m_pc);
        n_en    = w_ctrl ? d[0] : ((hit && m_oneshot) ? 1'b0 : m_en);
        m_irq   = m_match && m_irq_en;
        if (w_ctrl) begin
            m_irq_en  = d[1];
            m_oneshot = d[2];
            m_presc   = d[15:8];
        end
        if (w_cmp) m_cmp = d;
        m_en = n_en; m_match = n_match; m_count = n_count; m_inc = n_inc; m_pc = n_pc;
    endtask

    task automatic cycle(input logic wr, input logic [11:0] a, input logic [31:0] d);
        m_advance(wr, a, d);
        @(posedge clk);
        #1;
        check("irq", irq, m_irq);
        check("count", dut.count, m_count);
        check("match", dut.match, m_match);
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        logic err;
        err = m_err(a, 1'b1, d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        cycle(1'b0, a, d);
        check("wr_setup_pready", pready, 1'b0);
        penable = 1'b1;
        cycle(1'b0, a, d);
        check("wr_pready", pready, 1'b1);
        check("wr_pslverr", pslverr, err);
        cycle(!err, a, d);
        psel = 1'b0; penable = 1'b0;
        check("wr_end_pready", pready, 1'b0);
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] v, output logic e);
        logic [31:0] exp;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        cycle(1'b0, a, 32'd0);
        check("rd_setup_pready", pready, 1'b0);
        penable = 1'b1;
        exp = m_read(a);
        cycle(1'b0, a, 32'd0);
        check("rd_pready", pready, 1'b1);
        check("rd_pslverr", pslverr, m_err(a, 1'b0, 32'd0));
        check("rd_prdata", prdata, exp);
        v = prdata;
        e = pslverr;
        cycle(1'b0, a, 32'd0);
        psel = 1'b0; penable = 1'b0;
        check("rd_end_pready", pready, 1'b0);
    endtask

    logic [31:0] v;
    logic        e;
    logic [31:0] d;
    logic [11:0] a;

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_pready", pready, 1'b0);
        check("rst_pslverr", pslverr, 1'b0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_irq", irq, 1'b0);
        apb_read(12'h0, v, e);  check("rst_ctrl", v, 32'd0);
        apb_read(12'h4, v, e);  check("rst_count", v, 32'd0);
        apb_read(12'h8, v, e);  check("rst_cmp", v, 32'hFFFF_FFFF);
        apb_read(12'hC, v, e);  check("rst_status", v, 32'd0);

        // presc=0, CMP=5: COUNT hits 5 five clocks after enabling, then reloads
        apb_write(12'h8, 32'd5);
        apb_write(12'h0, 32'h1);
        repeat (5) cycle(1'b0, 12'h0, 32'd0);
        check("c5_count", dut.count, 32'd5);
        check("c5_match_early", dut.match, 1'b0);
        cycle(1'b0, 12'h0, 32'd0);
        check("c5_match", dut.match, 1'b1);
        check("c5_reload", dut.count, 32'd0);
        repeat (2) cycle(1'b0, 12'h0, 32'd0);
        check("c5_irq_masked", irq, 1'b0);
        apb_write(12'h0, 32'h0);

        // presc=3, oneshot, irq_en, CMP=2
        apb_write(12'h4, 32'd0);
        apb_write(12'hC, 32'd1);
        apb_write(12'h8, 32'd2);
        apb_write(12'h0, 32'h307);
        repeat (8) cycle(1'b0, 12'h0, 32'd0);
        check("os_count2", dut.count, 32'd2);
        cycle(1'b0, 12'h0, 32'd0);
        check("os_match", dut.match, 1'b1);
        check("os_irq_lag", irq, 1'b0);
        cycle(1'b0, 12'h0, 32'd0);
        check("os_irq", irq, 1'b1);
        apb_read(12'h0, v, e);  check("os_en_clear", v, 32'h306);

        // Illegal accesses: error response, zero data, nothing modified
        apb_read(12'h10, v, e); check("err10_data", v, 32'd0); check("err10_slverr", e, 1'b1);
        apb_read(12'h6, v, e);  check("err6_data", v, 32'd0);  check("err6_slverr", e, 1'b1);
        apb_write(12'h18, 32'h1234);
        apb_write(12'h9, 32'h55);
        apb_write(12'hC, 32'h3);
        apb_read(12'h8, v, e);  check("err_cmp_kept", v, 32'd2);
        apb_read(12'hC, v, e);  check("err_status_kept", v, 32'd1);

        // STATUS clear landing on the same edge as a match: set wins
        apb_write(12'h0, 32'h0);
        apb_write(12'hC, 32'd1);
        apb_write(12'h4, 32'd0);
        apb_write(12'h8, 32'd2);
        apb_write(12'h0, 32'h1);
        apb_write(12'hC, 32'd1);
        check("set_wins", dut.match, 1'b1);
        apb_write(12'h0, 32'h0);

        // COUNT wraps through 0xFFFF_FFFF to 0, which equals CMP=0
        apb_write(12'hC, 32'd1);
        apb_write(12'h4, 32'hFFFF_FFFE);
        apb_write(12'h8, 32'd0);
        apb_write(12'h0, 32'h1);
        cycle(1'b0, 12'h0, 32'd0);
        check("wrap_ffff", dut.count, 32'hFFFF_FFFF);
        cycle(1'b0, 12'h0, 32'd0);
        check("wrap_zero", dut.count, 32'd0);
        cycle(1'b0, 12'h0, 32'd0);
        check("wrap_match", dut.match, 1'b1);
        apb_write(12'h0, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 250; i++) begin
            int op;
            int sel;
            op  = int'($urandom_range(0, 9));
            sel = int'($urandom_range(0, 3));
            a   = 12'(sel * 4);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'($urandom_range(1, 3));
                else a[11:4] = 8'($urandom_range(1, 255));
            end
            if (op < 3) begin
                repeat ($urandom_range(1, 6)) cycle(1'b0, 12'h0, 32'd0);
            end else if (op < 7) begin
                d = $urandom();
                case (sel)
                    0: d[15:8] = 8'($urandom_range(0, 3));
                    1: d = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 12));
                    2: d = 32'($urandom_range(0, 12));
                    default: d = ($urandom_range(0, 5) == 0) ? 32'h2 : 32'($urandom_range(0, 1));
                endcase
                apb_write(a, d);
            end else begin
                apb_read(a, v, e);
            end
        end

        // Reset asserted in the first access cycle of a CMP write
        apb_write(12'h0, 32'h0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h8; pwdata = 32'h10;
        cycle(1'b0, 12'h8, 32'h10);
        penable = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("abort_pready", pready, 1'b0);
        repeat (2) @(posedge clk);
        psel = 1'b0; penable = 1'b0;
        #1;
        rst = 1'b0;
        m_reset();
        check("abort_pready_after", pready, 1'b0);
        apb_read(12'h8, v, e);  check("abort_cmp", v, 32'hFFFF_FFFF);
        apb_read(12'h0, v, e);  check("abort_ctrl", v, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/apb_timer.md
APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, width of paddr; registers decode paddr[3:2], upper bits SHALL be zero for a valid access.
REQ-002 SHALL have parameter PRESC_WIDTH, default 8, width of the prescaler field and counter.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 psel  input  1  select from the bridge mux (one psel bit).
REQ-007 penable  input  1  APB access phase.
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 paddr  input  APB_ADDR_WIDTH  byte address.
REQ-010 pwdata  input  32  write data.
REQ-011 prdata  output  32  read data, valid when pready=1 in access phase.
REQ-012 pready  output  1  transfer complete.
REQ-013 pslverr  output  1  error response, valid with pready.
REQ-014 irq  output  1  level interrupt, registered.

Function
REQ-015 Register map: 0x0 CTRL {[PRESC_WIDTH+7:8] presc, [2] oneshot, [1] irq_en, [0] en}; 0x4 COUNT rw; 0x8 CMP rw; 0xC STATUS {[0] match} write-1-to-clear; unused CTRL bits read 0.
REQ-016 Each access SHALL take exactly one wait state: in the first access-phase cycle pready=0; in the second, pready=1 and prdata/pslverr are valid.
REQ-017 Internal APB FSM states: IDLE (psel=0), SETUP (psel=1, penable=0), WAIT (first access cycle), DONE (pready=1), then IDLE or SETUP on back-to-back transfers.
REQ-018 psel deasserted in any state SHALL return the FSM to IDLE with no register side effect.
REQ-019 Writes SHALL commit on the DONE cycle only; reads SHALL sample on the WAIT cycle.
REQ-020 pslverr=1 with pready for paddr not word-aligned, upper bits nonzero, or writes to STATUS bits other than bit 0 set; erroneous writes SHALL NOT modify any register; prdata=0 when pslverr=1.
REQ-021 When en=1, prescaler counts 0..presc; on reaching presc it SHALL wrap to 0 and COUNT SHALL increment by 1 (presc=0 gives one increment per clk).
REQ-022 COUNT SHALL wrap 0xFFFF_FFFF -> 0 with no flag.
REQ-023 When incremented COUNT equals CMP, STATUS.match SHALL set the next cycle; COUNT SHALL reload 0; if oneshot=1, en SHALL clear the same cycle.
REQ-024 irq SHALL equal registered (match & irq_en).
REQ-025 A COUNT write in the same cycle as a tick SHALL win; the prescaler SHALL reset to 0 on any COUNT or CTRL write.
REQ-026 Match set and STATUS write-1-clear in the same cycle: set SHALL win.
REQ-027 en=0 SHALL freeze prescaler and COUNT.

Reset
REQ-028 On rst: CTRL=0, COUNT=0, CMP=0xFFFF_FFFF, STATUS=0, prescaler=0, FSM=IDLE, prdata=0, pready=0, pslverr=0, irq=0.
REQ-029 rst asserted mid-transfer SHALL abort it; no partial write SHALL persist after reset.

Structure
REQ-030 Register offsets, CTRL bit positions and the FSM state enum SHALL live in a shared package apb_timer_pkg.
REQ-031 The APB access FSM SHALL be a sub-module apb_slave_if (one wait state, write strobe, read strobe, error flag), reusable by other APB slaves on the bridge.
REQ-032 Timer datapath (prescaler, COUNT, CMP, match) SHALL stay in apb_timer.

Verification
REQ-033 Write CTRL=0x0000_0001, CMP=5, presc=0 -> COUNT reaches 5 after 5 clks, match=1 next cycle, COUNT reloads 0, irq stays 0.
REQ-034 CTRL=0x0000_0307 (presc=3, oneshot, irq_en, en), CMP=2 -> match after 8 clks, irq=1 one cycle later, en reads 0.
REQ-035 Read 0x10 and 0x6 -> pready=1 on second access cycle, pslverr=1, prdata=0, no register changes.
REQ-036 Write STATUS=1 in the same cycle match sets -> STATUS.match remains 1.
REQ-037 COUNT=0xFFFF_FFFE, CMP=0, en=1 -> wraps to 0 at the second tick, match set (COUNT==CMP).
REQ-038 Assert rst during WAIT of a CMP write of 0x10 -> CMP reads 0xFFFF_FFFF after reset, pready=0.
